// File: rtl/half_adder_checker.sv
// rtl/half_adder_checker.sv - response monitor comparing {a,b,sum,carry} samples to the half-adder function
module half_adder_checker #(
    parameter int CNT_W       = 8,
    parameter int EXP_VECTORS = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             in_sum,
    input  logic             in_carry,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [3:0]       first_err_vec
);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DONE} state_t;

    // Idle counter only ever needs to reach TIMEOUT-1.
    localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0]    IDLE_LAST = IW'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(EXP_VECTORS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t         state;
    logic [IW-1:0]  idle_cnt;
    logic           first_err_seen;
    logic           accept;
    logic           mismatch;

    assign in_ready = (state == S_CHECK);
    assign busy     = (state == S_CHECK);
    assign done     = (state == S_DONE);
    assign pass     = done & (err_count == '0) & ~timeout;
    assign accept   = in_valid & in_ready;
    assign mismatch = (in_sum != (in_a ^ in_b)) | (in_carry != (in_a & in_b));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            idle_cnt       <= '0;
            first_err_seen <= 1'b0;
            timeout        <= 1'b0;
            vec_count      <= '0;
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_vec  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state          <= S_CHECK;
                        idle_cnt       <= '0;
                        first_err_seen <= 1'b0;
                        timeout        <= 1'b0;
                        vec_count      <= '0;
                        err_count      <= '0;
                        first_err_idx  <= '0;
                        first_err_vec  <= '0;
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        vec_count <= vec_count + CNT_W'(1);
                        idle_cnt  <= '0;
                        if (mismatch) begin
                            if (err_count != CNT_MAX) begin
                                err_count <= err_count + CNT_W'(1);
                            end
                            if (!first_err_seen) begin
                                first_err_seen <= 1'b1;
                                first_err_idx  <= vec_count;
                                first_err_vec  <= {in_a, in_b, in_sum, in_carry};
                            end
                        end
                        // Completion on the last vector outranks a same-cycle timeout.
                        if (vec_count == LAST_IDX) begin
                            state <= S_DONE;
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        state   <= S_DONE;
                        timeout <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_half_adder_checker.sv
// tb/tb_half_adder_checker.sv - randomized self-checking bench for half_adder_checker
module tb_half_adder_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic       in_a, in_b, in_sum, in_carry;
    logic       in_ready, busy, done, pass, timeout;
    logic [7:0] vec_count, err_count, first_err_idx;
    logic [3:0] first_err_vec;

    int tests_run    = 0;
    int tests_failed = 0;

    half_adder_checker #(.CNT_W(8), .EXP_VECTORS(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .in_carry(in_carry),
        .in_ready(in_ready), .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .vec_count(vec_count), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_vec(first_err_vec)
    );

    always #5 clk = ~clk;

    // Expected {done, pass, timeout, vec_count, err_count, first_err_idx, first_err_vec}
    // for a completed run, from the arithmetic definition of a half adder.
    function automatic logic [30:0] model(input logic [3:0] v[$], input logic to);
        int ec = 0;
        int fi = 0;
        logic [3:0] fv = 4'b0;
        bit seen = 0;
        foreach (v[i]) begin
            int s = int'(v[i][3]) + int'(v[i][2]);
            if (int'(v[i][1]) != s % 2 || int'(v[i][0]) != s / 2) begin
                if (!seen) begin
                    fi = i;
                    fv = v[i];
                end
                seen = 1;
                ec++;
            end
        end
        return {1'b1, (ec == 0) && !to, to, 8'(v.size()), 8'(ec), 8'(fi), fv};
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] v);
        {in_a, in_b, in_sum, in_carry} = v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; in_valid = 1'b0;
        {in_a, in_b, in_sum, in_carry} = 4'b0;
        idle(2);
        tests_run++;
        if ({in_ready, busy, done, pass, timeout, vec_count, err_count, first_err_idx, first_err_vec} !== 33'b0) begin
            tests_failed++;
            $display("FAIL reset_state: got %b expected all zero",
                     {in_ready, busy, done, pass, timeout, vec_count, err_count, first_err_idx, first_err_vec});
        end
        rst = 1'b0; start = 1'b0;
        idle(1);
    endtask

    task automatic run_fixed(input string name, input logic [3:0] v[$]);
        do_start();
        tests_run++;
        if ({busy, in_ready} !== 2'b11) begin
            tests_failed++;
            $display("FAIL %s_start: busy/in_ready got %b expected 11", name, {busy, in_ready});
        end
        foreach (v[i]) send_keep(v[i]);
        in_valid = 1'b0;
        tests_run++;
        if ({done, pass, timeout, vec_count, err_count, first_err_idx, first_err_vec, in_ready} !== {model(v, 1'b0), 1'b0}) begin
            tests_failed++;
            $display("FAIL %s_result: got %h expected %h", name,
                     {done, pass, timeout, vec_count, err_count, first_err_idx, first_err_vec, in_ready},
                     {model(v, 1'b0), 1'b0});
        end
    endtask

    // Back-to-back variant of send: in_valid stays high across consecutive edges.
    task automatic send_keep(input logic [3:0] v);
        {in_a, in_b, in_sum, in_carry} = v;
        in_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [3:0] v[$] = '{4'b0000, 4'b0110, 4'b1010, 4'b1101};
        run_fixed("all_good", v);
    endtask

    task automatic test_single_err();
        logic [3:0] v[$] = '{4'b0000, 4'b0110, 4'b1000, 4'b1101};
        run_fixed("single_err", v);
    endtask

    task automatic test_two_err();
        logic [3:0] v[$] = '{4'b0000, 4'b0111, 4'b1010, 4'b1100};
        run_fixed("two_err", v);
    endtask

    task automatic test_timeout();
        logic [3:0] v[$] = '{4'b1101, 4'b0110};
        int early = 0;
        do_start();
        foreach (v[i]) send(v[i]);
        for (int k = 1; k < 64; k++) begin
            @(negedge clk);
            if (done) early++;
        end
        tests_run++;
        if (early != 0) begin
            tests_failed++;
            $display("FAIL timeout_early: done seen on %0d cycles, expected 0", early);
        end
        @(negedge clk);
        tests_run++;
        if ({done, pass, timeout, vec_count, err_count, first_err_idx, first_err_vec} !== model(v, 1'b1)) begin
            tests_failed++;
            $display("FAIL timeout_result: got %h expected %h",
                     {done, pass, timeout, vec_count, err_count, first_err_idx, first_err_vec}, model(v, 1'b1));
        end
    endtask

    task automatic test_gaps_done_valid();
        logic [3:0] v[$] = '{4'b1010, 4'b0000, 4'b1101, 4'b0110};
        do_start();
        foreach (v[i]) begin
            send(v[i]);
            if (i != 3) idle(3);
        end
        in_valid = 1'b1; idle(2); in_valid = 1'b0;
        tests_run++;
        if ({done, pass, timeout, vec_count, err_count, first_err_idx, first_err_vec} !== model(v, 1'b0)) begin
            tests_failed++;
            $display("FAIL gaps_result: got %h expected %h",
                     {done, pass, timeout, vec_count, err_count, first_err_idx, first_err_vec}, model(v, 1'b0));
        end
        do_start();
        tests_run++;
        if ({busy, done, vec_count, err_count} !== {2'b10, 16'h0}) begin
            tests_failed++;
            $display("FAIL restart_clear: got %h expected %h", {busy, done, vec_count, err_count}, {2'b10, 16'h0});
        end
        idle(70);
    endtask

    task automatic test_reset_mid();
        int done_seen = 0;
        do_start();
        send(4'b0000); send(4'b0111);
        rst = 1'b1;
        #1;
        tests_run++;
        if ({in_ready, busy, vec_count, err_count, first_err_idx, first_err_vec} !== 30'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: got %h expected 0",
                     {in_ready, busy, vec_count, err_count, first_err_idx, first_err_vec});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            send(4'b0000);
            if (done) done_seen++;
        end
        tests_run++;
        if (done_seen != 0 || vec_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_no_done: done %0d times, vec_count %0d, expected 0 and 0", done_seen, vec_count);
        end
        test_back_to_back();
    endtask

    task automatic test_random();
        for (int r = 0; r < 20; r++) begin
            logic [3:0] v[$];
            do_start();
            for (int i = 0; i < 4; i++) begin
                logic a = 1'($urandom);
                logic b = 1'($urandom);
                logic [1:0] flip = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                logic [3:0] s = {a, b, (a ^ b), (a & b)} ^ {2'b00, flip};
                v.push_back(s);
                send(s);
                idle($urandom_range(0, 3));
            end
            tests_run++;
            if ({done, pass, timeout, vec_count, err_count, first_err_idx, first_err_vec} !== model(v, 1'b0)) begin
                tests_failed++;
                $display("FAIL random_run%0d: got %h expected %h", r,
                         {done, pass, timeout, vec_count, err_count, first_err_idx, first_err_vec}, model(v, 1'b0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_single_err();
        test_two_err();
        test_timeout();
        test_gaps_done_valid();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
